// File: rtl/mem_stage_ws_if.sv
// EX -> MEM -> WB bundle of the mips_16 memory stage, including the stall
// back-pressure and the destination tap used by the hazard unit.
interface mem_stage_ws_if #(
  parameter int DATA_W = 16,
  parameter int DEST_W = 3
);
  logic              in_valid;
  logic [DATA_W-1:0] in_alu_result;
  logic              in_mem_read_en;
  logic              in_mem_write_en;
  logic [DATA_W-1:0] in_write_data;
  logic              in_wb_en;
  logic [DEST_W-1:0] in_wb_dest;
  logic              in_wb_mux;
  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_read_data;
  logic              out_wb_en;
  logic [DEST_W-1:0] out_wb_dest;
  logic              out_wb_mux;
  logic              out_addr_err;
  logic [DEST_W-1:0] mem_op_dest;
  logic              mem_op_dest_valid;

  modport master (
    output in_valid, in_alu_result, in_mem_read_en, in_mem_write_en,
           in_write_data, in_wb_en, in_wb_dest, in_wb_mux,
    input  stall, out_valid, out_alu_result, out_read_data, out_wb_en,
           out_wb_dest, out_wb_mux, out_addr_err, mem_op_dest, mem_op_dest_valid
  );

  modport slave (
    input  in_valid, in_alu_result, in_mem_read_en, in_mem_write_en,
           in_write_data, in_wb_en, in_wb_dest, in_wb_mux,
    output stall, out_valid, out_alu_result, out_read_data, out_wb_en,
           out_wb_dest, out_wb_mux, out_addr_err, mem_op_dest, mem_op_dest_valid
  );
endinterface

// File: rtl/mem_stage_ws.sv
// mips_16 memory stage: owns the data RAM, inserts WAIT_STATES extra cycles per
// memory access with a stall handshake, and flags out-of-range addresses.
module mem_stage_ws #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 128,
  parameter int DEST_W      = 3,
  parameter int WAIT_STATES = 0
) (
  input logic           clk,
  input logic           rst,
  mem_stage_ws_if.slave bus
);
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WS_C    = 4'(WAIT_STATES);
  localparam logic [DATA_W:0] DEPTH_C = (DATA_W + 1)'(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t            state_r, state_nx_s;
  logic [3:0]        cnt_r, cnt_nx_s;
  logic              hold_load_s;

  logic [DATA_W-1:0] hold_alu_r, hold_wdata_r;
  logic              hold_rd_r, hold_wr_r, hold_wb_en_r, hold_mux_r;
  logic [DEST_W-1:0] hold_dest_r;

  logic              accept_s, mem_op_in_s, complete_s;
  logic [DATA_W-1:0] c_alu_s, c_wdata_s, c_rdata_s;
  logic              c_rd_s, c_wr_s, c_wb_en_s, c_mux_s, c_mem_op_s, c_in_range_s;
  logic [DEST_W-1:0] c_dest_s;
  logic [AW-1:0]     c_idx_s;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              out_valid_r, out_wb_en_r, out_wb_mux_r, out_addr_err_r;
  logic [DATA_W-1:0] out_alu_result_r, out_read_data_r;
  logic [DEST_W-1:0] out_wb_dest_r;

  // Pick the bundle completing this edge: hold regs while busy, live inputs when idle.
  always_comb begin
    accept_s    = bus.in_valid && (state_r == ST_IDLE);
    mem_op_in_s = bus.in_mem_read_en | bus.in_mem_write_en;
    if (state_r == ST_BUSY) begin
      c_alu_s    = hold_alu_r;
      c_wdata_s  = hold_wdata_r;
      c_rd_s     = hold_rd_r;
      c_wr_s     = hold_wr_r;
      c_wb_en_s  = hold_wb_en_r;
      c_dest_s   = hold_dest_r;
      c_mux_s    = hold_mux_r;
      complete_s = (cnt_r == 4'd1);
    end else begin
      c_alu_s    = bus.in_alu_result;
      c_wdata_s  = bus.in_write_data;
      c_rd_s     = bus.in_mem_read_en;
      c_wr_s     = bus.in_mem_write_en;
      c_wb_en_s  = bus.in_wb_en;
      c_dest_s   = bus.in_wb_dest;
      c_mux_s    = bus.in_wb_mux;
      complete_s = accept_s && (!mem_op_in_s || (WS_C == 4'd0));
    end
    c_mem_op_s   = c_rd_s | c_wr_s;
    c_in_range_s = ({1'b0, c_alu_s} < DEPTH_C);
    c_idx_s      = c_alu_s[AW-1:0];
    // The combinational read sees the word before this edge's write lands.
    if (c_rd_s && c_in_range_s) begin
      c_rdata_s = mem_r[c_idx_s];
    end else begin
      c_rdata_s = {DATA_W{1'b0}};
    end
  end

  // FSM next-state and wait-state counter.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    hold_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && mem_op_in_s && (WS_C != 4'd0)) begin
          state_nx_s  = ST_BUSY;
          cnt_nx_s    = WS_C;
          hold_load_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 4'd1) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Capture a waiting memory op so upstream may move on once the stall drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_alu_r   <= {DATA_W{1'b0}};
      hold_wdata_r <= {DATA_W{1'b0}};
      hold_rd_r    <= 1'b0;
      hold_wr_r    <= 1'b0;
      hold_wb_en_r <= 1'b0;
      hold_dest_r  <= {DEST_W{1'b0}};
      hold_mux_r   <= 1'b0;
    end else if (hold_load_s) begin
      hold_alu_r   <= bus.in_alu_result;
      hold_wdata_r <= bus.in_write_data;
      hold_rd_r    <= bus.in_mem_read_en;
      hold_wr_r    <= bus.in_mem_write_en;
      hold_wb_en_r <= bus.in_wb_en;
      hold_dest_r  <= bus.in_wb_dest;
      hold_mux_r   <= bus.in_wb_mux;
    end
  end

  // Data RAM write port; reset discards any pending store and contents are kept.
  always_ff @(posedge clk) begin
    if (!rst && complete_s && c_wr_s && c_in_range_s) begin
      mem_r[c_idx_s] <= c_wdata_s;
    end
  end

  // Output bundle registers, loaded on the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r      <= 1'b0;
      out_alu_result_r <= {DATA_W{1'b0}};
      out_read_data_r  <= {DATA_W{1'b0}};
      out_wb_en_r      <= 1'b0;
      out_wb_dest_r    <= {DEST_W{1'b0}};
      out_wb_mux_r     <= 1'b0;
      out_addr_err_r   <= 1'b0;
    end else if (complete_s) begin
      out_valid_r      <= 1'b1;
      out_alu_result_r <= c_alu_s;
      out_read_data_r  <= c_rdata_s;
      out_wb_en_r      <= c_wb_en_s;
      out_wb_dest_r    <= c_dest_s;
      out_wb_mux_r     <= c_mux_s;
      out_addr_err_r   <= c_mem_op_s && !c_in_range_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Hazard tap: held instruction while busy, otherwise whatever EX presents.
  always_comb begin
    if (state_r == ST_BUSY) begin
      bus.mem_op_dest       = hold_dest_r;
      bus.mem_op_dest_valid = hold_wb_en_r;
    end else begin
      bus.mem_op_dest       = bus.in_wb_dest;
      bus.mem_op_dest_valid = bus.in_valid & bus.in_wb_en;
    end
  end

  assign bus.stall          = (state_r == ST_BUSY);
  assign bus.out_valid      = out_valid_r;
  assign bus.out_alu_result = out_alu_result_r;
  assign bus.out_read_data  = out_read_data_r;
  assign bus.out_wb_en      = out_wb_en_r;
  assign bus.out_wb_dest    = out_wb_dest_r;
  assign bus.out_wb_mux     = out_wb_mux_r;
  assign bus.out_addr_err   = out_addr_err_r;
endmodule
